uart_rx_parity: RTL and testbench

UART_RX_PARITY -- requirements
Module: uart_rx_parity

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_parity_if.sv | 32 +++
 rtl/uart_sync.sv | 26 ++
 rtl/uart_rx_parity.sv | 150 +++++++++++++++
 tb/tb_uart_rx_parity.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame constants and the
// parity helper, shared with the transmitter.
package uart_pkg;

    localparam int DATA_BITS          = 8;
    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Parity bit a well-formed frame carries: XOR of the data for even parity,
    // inverted for odd parity.
    function automatic logic exp_parity(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_parity_if.sv
// Receiver-side bus: oversample tick, serial line, consumer handshake,
// received byte with status flags, and the FSM state for observation.
//
// Handshake: the receiver raises ready when a byte lands in dout and holds
// dout/ready/flags stable until the consumer pulses rd_ack for one cycle
// while ready is high; the byte is consumed on that edge. rd_ack while ready
// is low is ignored. A new byte arriving before rd_ack overwrites dout and
// sets overrun.
interface uart_rx_parity_if;
    import uart_pkg::*;

    logic                 clk_en;
    logic                 rx;
    logic                 rd_ack;
    logic [DATA_BITS-1:0] dout;
    logic                 ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;
    rx_state_e            state;

    modport master (
        output clk_en, rx, rd_ack,
        input  dout, ready, parity_err, frame_err, overrun, state
    );

    modport slave (
        input  clk_en, rx, rd_ack,
        output dout, ready, parity_err, frame_err, overrun, state
    );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset
// to 1 so an idle line is not mistaken for a start bit after reset.
module uart_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage resynchronization into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_parity.sv
// UART receiver: 1 start, 8 data (LSB first), 1 parity, 1 stop bit, sampled
// at mid-bit on an oversample tick. Reports parity, framing and overrun.
module uart_rx_parity
    import uart_pkg::*;
#(
    parameter bit PARITY_ODD = 1'b0,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input logic             clk,
    input logic             reset,
    uart_rx_parity_if.slave bus
);

    localparam int              CW       = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]   CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam int              BW       = $clog2(DATA_BITS);
    localparam logic [BW-1:0]   BIT_LAST = BW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_pend_q, perr_pend_d;
    logic                 done;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 ready_q, ready_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    uart_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.rx),
        .q_o   (rx_s)
    );

    // Tick counter advance with wrap at the end of a bit period.
    assign cnt_inc = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

    // Frame FSM: start validation, mid-bit sampling of data/parity/stop.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        perr_pend_d = perr_pend_q;
        done        = 1'b0;
        if (bus.clk_en) begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (!rx_s) state_d = ST_START;
                end
                ST_START: begin
                    if (cnt_q == CNT_MID) begin
                        // Line back high at mid start bit: treat as a glitch.
                        cnt_d     = '0;
                        bit_cnt_d = '0;
                        state_d   = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    cnt_d = cnt_inc;
                    if (cnt_q == CNT_LAST) begin
                        shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    cnt_d = cnt_inc;
                    if (cnt_q == CNT_LAST) begin
                        perr_pend_d = (rx_s != exp_parity(shift_q, PARITY_ODD));
                        state_d     = ST_STOP;
                    end
                end
                ST_STOP: begin
                    cnt_d = cnt_inc;
                    if (cnt_q == CNT_LAST) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output holding register: load on frame completion, clear on acknowledge.
    always_comb begin
        dout_d  = dout_q;
        ready_d = ready_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        if (done) begin
            dout_d  = shift_q;
            ready_d = 1'b1;
            perr_d  = perr_pend_q;
            ferr_d  = ~rx_s;
            // An acknowledge in the completion cycle consumed the old byte.
            if (ready_q && !bus.rd_ack) ovr_d = 1'b1;
        end else if (bus.rd_ack && ready_q) begin
            ready_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // State, counters, shift register and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            perr_pend_q <= 1'b0;
            dout_q      <= '0;
            ready_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            perr_pend_q <= perr_pend_d;
            dout_q      <= dout_d;
            ready_q     <= ready_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.ready      = ready_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_uart_rx_parity.sv
// Directed bench for uart_rx_parity: an even-parity and an odd-parity
// receiver share one serial line and handshake.
module tb_uart_rx_parity;
  import uart_pkg::*;

  localparam int OS = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clk_en = 1'b0;
  logic rx = 1'b1;
  logic rd_ack = 1'b0;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic rb, ra;

  uart_rx_parity_if bus_e();
  uart_rx_parity_if bus_o();

  assign bus_e.clk_en = clk_en;
  assign bus_e.rx     = rx;
  assign bus_e.rd_ack = rd_ack;
  assign bus_o.clk_en = clk_en;
  assign bus_o.rx     = rx;
  assign bus_o.rd_ack = rd_ack;

  uart_rx_parity #(.PARITY_ODD(1'b0), .OVERSAMPLE(OS)) dut_even (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_e)
  );

  uart_rx_parity #(.PARITY_ODD(1'b1), .OVERSAMPLE(OS)) dut_odd (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_o)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One oversample tick: clk_en high for one clock, low for the next.
  task automatic tick();
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int n);
    rx = b;
    repeat (n) tick();
  endtask

  // Start, 8 data, parity, then stop bit up to just before its sample tick.
  task automatic send_head(input logic [7:0] d, input logic par, input logic stop);
    exp_q.push_back(d);
    send_bit(1'b0, OS);
    for (int i = 0; i < 8; i++) send_bit(d[i], OS);
    send_bit(par, OS);
    send_bit(stop, 9);
  endtask

  // The stop-sample tick; ready seen just before and just after its edge.
  task automatic stop_tick(input logic ack, output logic rdy_before, output logic rdy_after);
    clk_en = 1'b1;
    rd_ack = ack;
    #1 rdy_before = bus_e.ready;
    @(negedge clk);
    rdy_after = bus_e.ready;
    clk_en = 1'b0;
    rd_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_tail();
    repeat (OS - 10) tick();
    rx = 1'b1;
    repeat (12) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    logic b, a;
    send_head(d, par, stop);
    stop_tick(1'b0, b, a);
    send_tail();
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    @(negedge clk);
  endtask

  // Compare dout with the newest expected byte; older ones were overwritten.
  task automatic check_dout(input string tag);
    logic [7:0] e;
    e = (exp_q.size() > 0) ? exp_q[$] : 8'hxx;
    exp_q.delete();
    check(tag, bus_e.dout, e);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_dout", bus_e.dout, 8'h00);
    check("rst_ready", bus_e.ready, 1'b0);
    check("rst_perr", bus_e.parity_err, 1'b0);
    check("rst_ferr", bus_e.frame_err, 1'b0);
    check("rst_ovr", bus_e.overrun, 1'b0);
    check("rst_state", bus_e.state, ST_IDLE);
    reset = 1'b0;
    repeat (4) tick();

    // 0xA5 even parity 0, stop 1: clean, latency one clock after stop tick
    send_head(8'hA5, 1'b0, 1'b1);
    stop_tick(1'b0, rb, ra);
    check("a5_ready_before", rb, 1'b0);
    check("a5_ready_after", ra, 1'b1);
    send_tail();
    check_dout("a5_dout");
    check("a5_perr", bus_e.parity_err, 1'b0);
    check("a5_ferr", bus_e.frame_err, 1'b0);
    check("a5_ovr", bus_e.overrun, 1'b0);
    ack();
    check("a5_ack_ready", bus_e.ready, 1'b0);
    ack();
    check("ack_idle_ready", bus_e.ready, 1'b0);

    // 0x01 parity 0: wrong for even, right for odd
    send_frame(8'h01, 1'b0, 1'b1);
    check_dout("p01_dout");
    check("p01_even_perr", bus_e.parity_err, 1'b1);
    check("p01_even_ready", bus_e.ready, 1'b1);
    check("p01_odd_dout", bus_o.dout, 8'h01);
    check("p01_odd_perr", bus_o.parity_err, 1'b0);
    ack();

    // 0x3C with stop 0: framing error, cleared by ack
    send_frame(8'h3C, 1'b0, 1'b0);
    check_dout("f3c_dout");
    check("f3c_ferr", bus_e.frame_err, 1'b1);
    check("f3c_perr", bus_e.parity_err, 1'b0);
    check("f3c_ready", bus_e.ready, 1'b1);
    ack();
    check("f3c_ack_ready", bus_e.ready, 1'b0);
    check("f3c_ack_ferr", bus_e.frame_err, 1'b0);
    check("f3c_state", bus_e.state, ST_IDLE);

    // short low glitch, then a valid 0x55
    rx = 1'b0;
    repeat (4) tick();
    check("glitch_start", bus_e.state, ST_START);
    rx = 1'b1;
    repeat (12) tick();
    check("glitch_idle", bus_e.state, ST_IDLE);
    check("glitch_ready", bus_e.ready, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1);
    check_dout("g55_dout");
    check("g55_perr", bus_e.parity_err, 1'b0);
    check("g55_ferr", bus_e.frame_err, 1'b0);
    ack();

    // two bytes without ack: overrun
    send_frame(8'h11, 1'b0, 1'b1);
    check("ovr_first", bus_e.overrun, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1);
    check_dout("ovr_dout");
    check("ovr_ready", bus_e.ready, 1'b1);
    check("ovr_flag", bus_e.overrun, 1'b1);
    ack();
    check("ovr_ack_flag", bus_e.overrun, 1'b0);
    check("ovr_ack_ready", bus_e.ready, 1'b0);

    // ack in the same cycle as the second completion
    send_frame(8'h11, 1'b0, 1'b1);
    send_head(8'h22, 1'b0, 1'b1);
    stop_tick(1'b1, rb, ra);
    check("same_ready", ra, 1'b1);
    check("same_ovr", bus_e.overrun, 1'b0);
    send_tail();
    check_dout("same_dout");
    check("same_ready_hold", bus_e.ready, 1'b1);

    // reset during data bit 4 of 0xF0 (ready/dout still hold 0x22)
    send_bit(1'b0, OS);
    for (int i = 0; i < 4; i++) send_bit(1'b0, OS);
    send_bit(1'b1, 8);
    check("mid_state", bus_e.state, ST_DATA);
    reset = 1'b1;
    #1;
    check("mid_rst_dout", bus_e.dout, 8'h00);
    check("mid_rst_ready", bus_e.ready, 1'b0);
    check("mid_rst_ovr", bus_e.overrun, 1'b0);
    check("mid_rst_state", bus_e.state, ST_IDLE);
    @(negedge clk);
    reset = 1'b0;
    rx = 1'b1;
    repeat (4) tick();
    send_frame(8'hF0, 1'b0, 1'b1);
    check_dout("f0_dout");
    check("f0_ready", bus_e.ready, 1'b1);
    check("f0_perr", bus_e.parity_err, 1'b0);
    check("f0_ferr", bus_e.frame_err, 1'b0);
    check("f0_ovr", bus_e.overrun, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
